// File: rtl/key_entry_decoder.sv
// key_entry_decoder: captures an operator or digit entry from the switches on each debounced confirm press.
// Optional cancel button and its debouncer are built when KEY_ENTRY_CANCEL_BTN_EN is defined.
module key_entry_decoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_btn_confirm,
`ifdef KEY_ENTRY_CANCEL_BTN_EN
    input  logic       i_btn_cancel,
`endif
    input  logic       i_mode,
    input  logic [7:0] i_sw,
    output logic       o_valid,
    output logic       o_err,
    output logic       o_mode,
    output logic [2:0] o_op_code,
    output logic [3:0] o_digit_val,
    output logic       o_have,
    output logic       o_busy
);

    // state    | meaning
    // IDLE     | waiting for a confirm press
    // CAPTURE  | validating the synchronized mode and switches
    // COMMIT   | entry accepted, o_valid pulsing
    // ERROR    | entry rejected, o_err pulsing
    // WAIT_REL | waiting for confirm to debounce back to released
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CAPTURE  = 3'd1,
        S_COMMIT   = 3'd2,
        S_ERROR    = 3'd3,
        S_WAIT_REL = 3'd4
    } state_t;

    localparam logic [15:0] C_DB_TC = 16'(DEBOUNCE_CYCLES - 1);

    logic        r_conf_s1;
    logic        r_conf_s2;
    logic        r_conf_deb;
    logic        r_conf_deb_d;
    logic [15:0] r_conf_cnt;
    logic        r_mode_s1;
    logic        r_mode_s2;
    logic [7:0]  r_sw_s1;
    logic [7:0]  r_sw_s2;

    logic        w_conf_press;
    logic        w_cancel_press;
    logic        w_legal;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_valid;
    logic        r_err;
    logic        r_mode;
    logic [2:0]  r_op;
    logic [3:0]  r_digit;
    logic        r_have;
    logic        r_busy;

    logic        w_valid_nxt;
    logic        w_err_nxt;
    logic        w_mode_nxt;
    logic [2:0]  w_op_nxt;
    logic [3:0]  w_digit_nxt;
    logic        w_have_nxt;

    // Debounced level moves only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_conf_s1    <= 1'b0;
            r_conf_s2    <= 1'b0;
            r_conf_deb   <= 1'b0;
            r_conf_deb_d <= 1'b0;
            r_conf_cnt   <= '0;
        end else begin
            r_conf_s1    <= i_btn_confirm;
            r_conf_s2    <= r_conf_s1;
            r_conf_deb_d <= r_conf_deb;
            if (r_conf_s2 == r_conf_deb) begin
                r_conf_cnt <= '0;
            end else if (r_conf_cnt == C_DB_TC) begin
                r_conf_deb <= r_conf_s2;
                r_conf_cnt <= '0;
            end else begin
                r_conf_cnt <= r_conf_cnt + 16'd1;
            end
        end
    end

    assign w_conf_press = r_conf_deb & ~r_conf_deb_d;

`ifdef KEY_ENTRY_CANCEL_BTN_EN
    logic        r_canc_s1;
    logic        r_canc_s2;
    logic        r_canc_deb;
    logic        r_canc_deb_d;
    logic [15:0] r_canc_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_canc_s1    <= 1'b0;
            r_canc_s2    <= 1'b0;
            r_canc_deb   <= 1'b0;
            r_canc_deb_d <= 1'b0;
            r_canc_cnt   <= '0;
        end else begin
            r_canc_s1    <= i_btn_cancel;
            r_canc_s2    <= r_canc_s1;
            r_canc_deb_d <= r_canc_deb;
            if (r_canc_s2 == r_canc_deb) begin
                r_canc_cnt <= '0;
            end else if (r_canc_cnt == C_DB_TC) begin
                r_canc_deb <= r_canc_s2;
                r_canc_cnt <= '0;
            end else begin
                r_canc_cnt <= r_canc_cnt + 16'd1;
            end
        end
    end

    assign w_cancel_press = r_canc_deb & ~r_canc_deb_d;
`else
    assign w_cancel_press = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode_s1 <= 1'b0;
            r_mode_s2 <= 1'b0;
            r_sw_s1   <= '0;
            r_sw_s2   <= '0;
        end else begin
            r_mode_s1 <= i_mode;
            r_mode_s2 <= r_mode_s1;
            r_sw_s1   <= i_sw;
            r_sw_s2   <= r_sw_s1;
        end
    end

    assign w_legal = r_mode_s2 ? (r_sw_s2[7:4] == 4'd0) : (r_sw_s2[7:2] == 6'd0);

    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = 1'b0;
        w_err_nxt   = 1'b0;
        w_mode_nxt  = r_mode;
        w_op_nxt    = r_op;
        w_digit_nxt = r_digit;
        w_have_nxt  = r_have;
        case (r_state)
            S_IDLE: begin
                if (w_conf_press) w_state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (w_legal) begin
                    w_state_nxt = S_COMMIT;
                    w_valid_nxt = 1'b1;
                    w_mode_nxt  = r_mode_s2;
                    w_have_nxt  = 1'b1;
                    if (r_mode_s2) w_digit_nxt = r_sw_s2[3:0];
                    else           w_op_nxt    = r_sw_s2[2:0];
                end else begin
                    w_state_nxt = S_ERROR;
                    w_err_nxt   = 1'b1;
                end
            end
            S_COMMIT, S_ERROR: w_state_nxt = S_WAIT_REL;
            S_WAIT_REL: begin
                if (!r_conf_deb) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Cancel overrides everything, including a commit landing this cycle.
        if (w_cancel_press) begin
            w_state_nxt = (r_state == S_IDLE) ? S_IDLE : S_WAIT_REL;
            w_valid_nxt = 1'b0;
            w_err_nxt   = 1'b0;
            w_mode_nxt  = 1'b0;
            w_op_nxt    = '0;
            w_digit_nxt = '0;
            w_have_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_mode  <= 1'b0;
            r_op    <= '0;
            r_digit <= '0;
            r_have  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= w_valid_nxt;
            r_err   <= w_err_nxt;
            r_mode  <= w_mode_nxt;
            r_op    <= w_op_nxt;
            r_digit <= w_digit_nxt;
            r_have  <= w_have_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
        end
    end

    assign o_valid     = r_valid;
    assign o_err       = r_err;
    assign o_mode      = r_mode;
    assign o_op_code   = r_op;
    assign o_digit_val = r_digit;
    assign o_have      = r_have;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_key_entry_decoder.sv
// Self-checking bench for key_entry_decoder: directed scenarios plus randomized entries against a reference model.
// Define KEY_ENTRY_CANCEL_BTN_EN to also exercise the cancel button.
module tb_key_entry_decoder;
    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_confirm = 1'b0;
    logic       btn_cancel = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] sw = 8'd0;

    logic       o_valid;
    logic       o_err;
    logic       o_mode;
    logic [2:0] o_op_code;
    logic [3:0] o_digit_val;
    logic       o_have;
    logic       o_busy;

    int    checks = 0;
    int    failures = 0;
    int    n_valid = 0;
    int    n_err = 0;
    string phase = "init";

    // Reference model: raw samples delayed two cycles, run-length debounce, cycles-since-press sequencing.
    logic [10:0] m_q[$];
    logic [1:0]  m_deb = 2'b00;
    logic [1:0]  m_deb_prev = 2'b00;
    int          m_run[2] = '{0, 0};
    int          m_since = -1;
    logic        m_valid = 1'b0;
    logic        m_err = 1'b0;
    logic        m_mode = 1'b0;
    logic [2:0]  m_op = 3'd0;
    logic [3:0]  m_digit = 4'd0;
    logic        m_have = 1'b0;
    logic        m_busy = 1'b0;

    always #5 clk = ~clk;

    key_entry_decoder #(.DEBOUNCE_CYCLES(N)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_btn_confirm (btn_confirm),
`ifdef KEY_ENTRY_CANCEL_BTN_EN
        .i_btn_cancel  (btn_cancel),
`endif
        .i_mode        (mode),
        .i_sw          (sw),
        .o_valid       (o_valid),
        .o_err         (o_err),
        .o_mode        (o_mode),
        .o_op_code     (o_op_code),
        .o_digit_val   (o_digit_val),
        .o_have        (o_have),
        .o_busy        (o_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic [10:0] s;
        logic        conf_press;
        logic        canc_press;
        logic        conf_pre;
        if (rst) begin
            m_q = '{11'd0, 11'd0};
            m_deb = 2'b00;
            m_deb_prev = 2'b00;
            m_run = '{0, 0};
            m_since = -1;
            m_valid = 1'b0;
            m_err = 1'b0;
            m_mode = 1'b0;
            m_op = 3'd0;
            m_digit = 4'd0;
            m_have = 1'b0;
            m_busy = 1'b0;
        end else begin
            s = m_q.pop_front();
            m_q.push_back({btn_cancel, btn_confirm, mode, sw});
            conf_press = m_deb[0] & ~m_deb_prev[0];
            canc_press = m_deb[1] & ~m_deb_prev[1];
            conf_pre = m_deb[0];
            m_deb_prev = m_deb;
            m_valid = 1'b0;
            m_err = 1'b0;
            if (canc_press) begin
                if (m_since >= 0) m_since = 2;
                m_have = 1'b0;
                m_mode = 1'b0;
                m_op = 3'd0;
                m_digit = 4'd0;
            end else if (m_since < 0) begin
                if (conf_press) m_since = 0;
            end else if (m_since == 0) begin
                if (s[8] ? (s[7:0] < 8'd16) : (s[7:0] < 8'd4)) begin
                    m_valid = 1'b1;
                    m_mode = s[8];
                    m_have = 1'b1;
                    if (s[8]) m_digit = s[3:0];
                    else      m_op = s[2:0];
                end else begin
                    m_err = 1'b1;
                end
                m_since = 1;
            end else if (m_since == 1) begin
                m_since = 2;
            end else if (!conf_pre) begin
                m_since = -1;
            end
            for (int b = 0; b < 2; b++) begin
                if (s[9 + b] == m_deb[b]) begin
                    m_run[b] = 0;
                end else begin
                    m_run[b] = m_run[b] + 1;
                    if (m_run[b] == N) begin
                        m_deb[b] = s[9 + b];
                        m_run[b] = 0;
                    end
                end
            end
            m_busy = (m_since >= 0);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            #1;
            chk("valid", 32'(o_valid), 32'(m_valid));
            chk("err", 32'(o_err), 32'(m_err));
            chk("mode", 32'(o_mode), 32'(m_mode));
            chk("op_code", 32'(o_op_code), 32'(m_op));
            chk("digit_val", 32'(o_digit_val), 32'(m_digit));
            chk("have", 32'(o_have), 32'(m_have));
            chk("busy", 32'(o_busy), 32'(m_busy));
            chk("valid_err_excl", 32'(o_valid & o_err), 32'd0);
            if (o_valid) n_valid++;
            if (o_err) n_err++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        m_q = '{11'd0, 11'd0};

        phase = "reset";
        tick(3);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_have", 32'(o_have), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_digit", 32'(o_digit_val), 32'd0);
        rst = 1'b0;
        tick(2);

        phase = "digit12";
        n_valid = 0;
        mode = 1'b1;
        sw = 8'h0C;
        btn_confirm = 1'b1;
        tick(20);
        btn_confirm = 1'b0;
        tick(12);
        chk("n_valid", 32'(n_valid), 32'd1);
        chk("digit", 32'(o_digit_val), 32'd12);
        chk("mode1", 32'(o_mode), 32'd1);
        chk("have1", 32'(o_have), 32'd1);

        phase = "op_illegal";
        n_valid = 0;
        n_err = 0;
        mode = 1'b0;
        sw = 8'h05;
        btn_confirm = 1'b1;
        tick(10);
        btn_confirm = 1'b0;
        tick(12);
        chk("n_err", 32'(n_err), 32'd1);
        chk("n_valid", 32'(n_valid), 32'd0);
        chk("digit_kept", 32'(o_digit_val), 32'd12);
        chk("mode_kept", 32'(o_mode), 32'd1);
        chk("op_kept", 32'(o_op_code), 32'd0);

        phase = "op3";
        n_valid = 0;
        sw = 8'h03;
        btn_confirm = 1'b1;
        tick(10);
        btn_confirm = 1'b0;
        tick(12);
        chk("n_valid", 32'(n_valid), 32'd1);
        chk("op", 32'(o_op_code), 32'd3);
        chk("mode0", 32'(o_mode), 32'd0);
        chk("digit_kept", 32'(o_digit_val), 32'd12);

        phase = "bounce";
        n_valid = 0;
        n_err = 0;
        for (int i = 0; i < 15; i++) begin
            btn_confirm = ~btn_confirm;
            tick(2);
        end
        btn_confirm = 1'b0;
        tick(8);
        chk("n_valid", 32'(n_valid), 32'd0);
        chk("n_err", 32'(n_err), 32'd0);
        chk("idle", 32'(o_busy), 32'd0);

        phase = "long_hold";
        n_valid = 0;
        mode = 1'b1;
        sw = 8'h0A;
        btn_confirm = 1'b1;
        tick(200);
        chk("n_valid", 32'(n_valid), 32'd1);
        chk("wait_rel_busy", 32'(o_busy), 32'd1);
        btn_confirm = 1'b0;
        tick(12);
        chk("released_idle", 32'(o_busy), 32'd0);

        phase = "rst_capture";
        mode = 1'b1;
        sw = 8'h09;
        btn_confirm = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (o_busy) break;
        end
        chk("reach_capture", 32'(o_busy), 32'd1);
        n_valid = 0;
        n_err = 0;
        rst = 1'b1;
        tick(1);
        chk("valid0", 32'(o_valid), 32'd0);
        chk("err0", 32'(o_err), 32'd0);
        chk("have0", 32'(o_have), 32'd0);
        chk("mode0", 32'(o_mode), 32'd0);
        chk("digit0", 32'(o_digit_val), 32'd0);
        chk("busy0", 32'(o_busy), 32'd0);
        tick(2);
        rst = 1'b0;
        tick(20);
        chk("fresh_press", 32'(n_valid), 32'd1);
        chk("digit9", 32'(o_digit_val), 32'd9);
        btn_confirm = 1'b0;
        tick(12);

        phase = "random";
        for (int e = 0; e < 40; e++) begin
            mode = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0:       sw = 8'($urandom_range(0, 3));
                1:       sw = 8'($urandom_range(0, 15));
                default: sw = 8'($urandom_range(0, 255));
            endcase
            if ($urandom_range(0, 3) == 0) begin
                btn_confirm = 1'b1;
                tick(int'($urandom_range(1, 3)));
                btn_confirm = 1'b0;
                tick(1);
            end
            btn_confirm = 1'b1;
`ifdef KEY_ENTRY_CANCEL_BTN_EN
            if ($urandom_range(0, 3) == 0) btn_cancel = 1'b1;
`endif
            tick(int'($urandom_range(2, 8)));
            if ($urandom_range(0, 1) == 1) sw = 8'($urandom);
            tick(int'($urandom_range(2, 20)));
            btn_confirm = 1'b0;
            btn_cancel = 1'b0;
            tick(int'($urandom_range(3, 14)));
        end
        btn_confirm = 1'b0;
        tick(12);

`ifdef KEY_ENTRY_CANCEL_BTN_EN
        phase = "cancel_same";
        mode = 1'b1;
        sw = 8'h07;
        btn_confirm = 1'b1;
        tick(10);
        btn_confirm = 1'b0;
        tick(12);
        chk("have_before", 32'(o_have), 32'd1);
        n_valid = 0;
        btn_confirm = 1'b1;
        btn_cancel = 1'b1;
        tick(10);
        chk("n_valid", 32'(n_valid), 32'd0);
        chk("have_cleared", 32'(o_have), 32'd0);
        chk("digit_cleared", 32'(o_digit_val), 32'd0);
        btn_confirm = 1'b0;
        btn_cancel = 1'b0;
        tick(12);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_entry_decoder.md
KEY_ENTRY_DECODER -- requirements
Module: key_entry_decoder

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 20000: the number of consecutive stable synchronized cycles needed to accept a new button level; legal range 2..65535.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port i_btn_confirm, input, 1 bit: raw asynchronous confirm button, high = pressed.
REQ-005 SHALL have port i_btn_cancel, input, 1 bit: raw asynchronous cancel button, present only with CANCEL_BTN_EN.
REQ-006 SHALL have port i_mode, input, 1 bit: raw switch; 0 = operator entry, 1 = digit entry.
REQ-007 SHALL have port i_sw, input, 8 bits: raw data switches.
REQ-008 SHALL have port o_valid, output, 1 bit: one-cycle pulse on an accepted entry.
REQ-009 SHALL have port o_err, output, 1 bit: one-cycle pulse on a rejected entry.
REQ-010 SHALL have port o_mode, output, 1 bit: mode of the last accepted entry.
REQ-011 SHALL have port o_op_code, output, 3 bits: last accepted operator code, 0..3 (T/A/B/C).
REQ-012 SHALL have port o_digit_val, output, 4 bits: last accepted digit, 0..15.
REQ-013 SHALL have port o_have, output, 1 bit: a held entry exists; drives display enable.
REQ-014 SHALL have port o_busy, output, 1 bit: high in every state except IDLE.

Function
REQ-015 SHALL pass i_btn_confirm, i_btn_cancel, i_mode and i_sw through two-flop synchronizers before any use.
REQ-016 SHALL debounce each button with its own counter: the debounced level changes only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any sample equal to the current debounced level clears the counter.
REQ-017 SHALL produce a press edge for exactly one cycle on each debounced 0->1 transition.
REQ-018 SHALL implement the FSM states IDLE, CAPTURE, COMMIT, ERROR and WAIT_REL.
REQ-019 SHALL move IDLE->CAPTURE on the cycle after a confirm press edge; a press edge outside IDLE SHALL be ignored.
REQ-020 SHALL, in CAPTURE, sample the synchronized i_mode and i_sw and validate them.
  - Mode 0 is legal when sw[7:2]==0; it takes op = sw[2:0].
  - Mode 1 is legal when sw[7:4]==0; it takes digit = sw[3:0].
REQ-021 SHALL go CAPTURE->COMMIT when the sample is legal, otherwise CAPTURE->ERROR.
REQ-022 SHALL, in COMMIT:
  - assert o_valid for one cycle;
  - update o_mode, and update o_op_code (mode 0) or o_digit_val (mode 1), leaving the other field unchanged;
  - set o_have.
REQ-023 SHALL, in ERROR, assert o_err for one cycle and leave all held outputs and o_have unchanged.
REQ-024 SHALL go from COMMIT or ERROR to WAIT_REL, and from WAIT_REL to IDLE on the first cycle the debounced confirm is 0.
REQ-025 SHALL give o_valid/o_err exactly 2 cycles after the press-edge cycle.
REQ-026 SHALL ensure o_valid and o_err are never high together.
REQ-027 SHALL register all outputs.

Reset
REQ-028 SHALL, while rst is high at a clock edge, force:
  - FSM to IDLE;
  - synchronizers, debounced levels and debounce counters to 0;
  - o_valid, o_err, o_mode, o_op_code, o_digit_val, o_have and o_busy to 0.
REQ-029 SHALL, when reset is asserted mid-operation (any state), abort the operation with no o_valid/o_err pulse; after release, a button held through reset SHALL first debounce to 1 and then produce a fresh press edge.

Configuration
REQ-030 SHALL, with macro KEY_ENTRY_CANCEL_BTN_EN defined, include i_btn_cancel and its debouncer. A cancel press edge in any state SHALL:
  - clear o_have, o_op_code, o_digit_val and o_mode to 0 on the next cycle;
  - return the FSM to WAIT_REL if it is not in IDLE;
  - suppress any o_valid/o_err pulse due that cycle (cancel wins over a simultaneous commit).
REQ-031 SHALL, without KEY_ENTRY_CANCEL_BTN_EN, omit the port and its logic; o_have then stays 1 after the first commit until reset.

Verification
REQ-032 SHALL cover (DEBOUNCE_CYCLES=4 in every scenario): mode=1, sw=0x0C, confirm held 20 cycles -> a single o_valid, o_digit_val=12, o_mode=1, o_have=1.
REQ-033 SHALL cover: mode=0, sw=0x05 with confirm -> o_err one cycle, held outputs unchanged; mode=0, sw=0x03 -> o_valid, o_op_code=3.
REQ-034 SHALL cover: confirm toggling every 2 cycles for 30 cycles -> no press edge, no pulse, o_busy=0.
REQ-035 SHALL cover: confirm held 200 cycles -> exactly one o_valid; FSM in WAIT_REL until release debounces.
REQ-036 SHALL cover: rst asserted while in CAPTURE -> next cycle all outputs 0, no pulse.
REQ-037 SHALL cover (KEY_ENTRY_CANCEL_BTN_EN): confirm and cancel press edges in the same cycle -> no o_valid, o_have=0, o_digit_val=0.
